// File: rtl/complete_arbiter_if.sv
// Completion-port bundle between execution-unit requesters and the commit queue.
// master drives requests and commit-queue back-pressure; slave is the arbiter.
interface complete_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 44
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_en;
  logic [N_REQ-1:0][W-1:0] req_msg;
  logic [N_REQ-1:0]        req_reject;
  logic                    out_en;
  logic [W-1:0]            out_msg;
  logic                    out_reject;
  logic [GW-1:0]           grant_id;

  modport master (
    output req_en, req_msg, out_reject,
    input  req_reject, out_en, out_msg, grant_id
  );

  modport slave (
    input  req_en, req_msg, out_reject,
    output req_reject, out_en, out_msg, grant_id
  );
endinterface

// File: rtl/complete_arbiter.sv
// Round-robin arbiter merging per-requester completion FIFOs into one
// registered completion port; messages pass through untouched.
module complete_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 44,
  parameter int DEPTH = 2
) (
  input logic              clock,
  input logic              reset,
  complete_arbiter_if.slave bus
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]     mem    [N_REQ][DEPTH];
  logic [PW-1:0]    wr_ptr [N_REQ];
  logic [PW-1:0]    rd_ptr [N_REQ];
  logic [CW-1:0]    count  [N_REQ];
  logic [GW-1:0]    last_grant;
  logic [GW-1:0]    winner;
  logic             found;
  logic             load;
  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] pop;
  logic [N_REQ-1:0] nonempty;

  // Reject depends only on registered counts, so a full FIFO stays closed
  // for the whole cycle even if it is popped at the same edge.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_reject[i] = (count[i] == CW'(DEPTH));
      nonempty[i]       = (count[i] != '0);
      push[i]           = bus.req_en[i] && !bus.req_reject[i];
    end
  end

  assign load = !bus.out_en || !bus.out_reject;

  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(last_grant) + 1 + k) % N_REQ;
      if (!found && nonempty[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      pop[i] = load && found && (winner == GW'(i));
    end
  end

  // Storage carries no reset; only pointers and counts define valid entries.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= bus.req_msg[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.out_en   <= 1'b0;
      bus.out_msg  <= '0;
      bus.grant_id <= '0;
      last_grant   <= GW'(N_REQ - 1);
    end else if (load) begin
      if (found) begin
        bus.out_en   <= 1'b1;
        bus.out_msg  <= mem[winner][rd_ptr[winner]];
        bus.grant_id <= winner;
        last_grant   <= winner;
      end else begin
        bus.out_en <= 1'b0;
      end
    end
  end
endmodule
